// File: rtl/regfile_bypass_init.sv
// Register file with three combinational read ports, a core write port and a
// memory-writeback port. After reset it walks every register to zero before
// reporting INIT_DONE_O; writeback requests losing an address conflict to the
// core port are stalled, and the stalled cycles are counted.
module regfile_bypass_init #(
    parameter int DATA_WIDTH         = 32,
    parameter int REGFILE_SIZE       = 16,
    parameter int REGFILE_ADDR_WIDTH = 4,
    parameter int BYPASS             = 1
) (
    input  logic                          CLK_I,
    input  logic                          RST_I,
    input  logic                          EN_I,
    input  logic [REGFILE_ADDR_WIDTH-1:0] RD_PORT_DIRECT_ADDR_I,
    input  logic [REGFILE_ADDR_WIDTH-1:0] RD_PORT_MUX_ADDR_I,
    input  logic [REGFILE_ADDR_WIDTH-1:0] RD_PORT_CACHE_ADDR_I,
    output logic [DATA_WIDTH-1:0]         RD_PORT_DIRECT_O,
    output logic [DATA_WIDTH-1:0]         RD_PORT_MUX_O,
    output logic [DATA_WIDTH-1:0]         RD_PORT_CACHE_O,
    input  logic                          WR_PORT_EN_I,
    input  logic [REGFILE_ADDR_WIDTH-1:0] WR_PORT_ADDR_I,
    input  logic [DATA_WIDTH-1:0]         WR_PORT_DATA_I,
    input  logic                          MEM_WR_VALID_I,
    input  logic [REGFILE_ADDR_WIDTH-1:0] MEM_WR_ADDR_I,
    input  logic [DATA_WIDTH-1:0]         MEM_WR_DATA_I,
    output logic                          MEM_WR_READY_O,
    output logic                          INIT_DONE_O,
    output logic [15:0]                   MEM_STALL_CNT_O
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [REGFILE_ADDR_WIDTH-1:0] CLR_LAST = REGFILE_ADDR_WIDTH'(REGFILE_SIZE - 1);

    state_t                          state_q;
    state_t                          state_d;
    logic [REGFILE_ADDR_WIDTH-1:0]   clr_cnt;
    logic [DATA_WIDTH-1:0]           mem [REGFILE_SIZE];

    logic                            run_active;
    logic                            clear_wr;
    logic                            core_wr;
    logic                            mem_ready;
    logic                            mem_wr;
    logic [REGFILE_ADDR_WIDTH-1:0]   rd_addr [3];
    logic [DATA_WIDTH-1:0]           rd_data [3];

    function automatic logic in_range(input logic [REGFILE_ADDR_WIDTH-1:0] a);
        return 32'(a) < 32'(REGFILE_SIZE);
    endfunction

    // Next state and write-port arbitration; reset blocks every write and handshake.
    always_comb begin
        state_d    = state_q;
        run_active = 1'b0;
        clear_wr   = 1'b0;
        core_wr    = 1'b0;
        mem_ready  = 1'b0;
        mem_wr     = 1'b0;
        if (state_q == ST_CLEAR && clr_cnt == CLR_LAST) begin
            state_d = ST_RUN;
        end
        if (!RST_I) begin
            run_active = (state_q == ST_RUN);
            clear_wr   = (state_q == ST_CLEAR);
        end
        // Out-of-range writes still handshake but never reach the array.
        core_wr   = run_active && EN_I && WR_PORT_EN_I && in_range(WR_PORT_ADDR_I);
        mem_ready = run_active && EN_I &&
                    !(WR_PORT_EN_I && (WR_PORT_ADDR_I == MEM_WR_ADDR_I));
        mem_wr    = MEM_WR_VALID_I && mem_ready && in_range(MEM_WR_ADDR_I);
        MEM_WR_READY_O = mem_ready;
        INIT_DONE_O    = (state_q == ST_RUN);
    end

    // FSM register, clear walker and saturating stall counter.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q         <= ST_CLEAR;
            clr_cnt         <= '0;
            MEM_STALL_CNT_O <= '0;
        end else begin
            state_q <= state_d;
            if (clear_wr) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
            if (run_active && MEM_WR_VALID_I && !mem_ready && MEM_STALL_CNT_O != '1) begin
                MEM_STALL_CNT_O <= MEM_STALL_CNT_O + 1'b1;
            end
        end
    end

    // Storage array; conflicting addresses never reach both ports in one cycle.
    always_ff @(posedge CLK_I) begin
        if (clear_wr) begin
            mem[clr_cnt] <= '0;
        end else begin
            if (mem_wr) begin
                mem[MEM_WR_ADDR_I] <= MEM_WR_DATA_I;
            end
            if (core_wr) begin
                mem[WR_PORT_ADDR_I] <= WR_PORT_DATA_I;
            end
        end
    end

    // Read ports: zero outside RUN or out of range, optional same-cycle forwarding.
    always_comb begin
        rd_addr[0] = RD_PORT_DIRECT_ADDR_I;
        rd_addr[1] = RD_PORT_MUX_ADDR_I;
        rd_addr[2] = RD_PORT_CACHE_ADDR_I;
        for (int unsigned i = 0; i < 3; i++) begin
            rd_data[i] = '0;
            if (run_active && in_range(rd_addr[i])) begin
                rd_data[i] = mem[rd_addr[i]];
                if (BYPASS != 0) begin
                    if (core_wr && WR_PORT_ADDR_I == rd_addr[i]) begin
                        rd_data[i] = WR_PORT_DATA_I;
                    end else if (mem_wr && MEM_WR_ADDR_I == rd_addr[i]) begin
                        rd_data[i] = MEM_WR_DATA_I;
                    end
                end
            end
        end
        RD_PORT_DIRECT_O = rd_data[0];
        RD_PORT_MUX_O    = rd_data[1];
        RD_PORT_CACHE_O  = rd_data[2];
    end

endmodule

// File: tb/tb_regfile_bypass_init.sv
// Scoreboard bench for regfile_bypass_init. Three instances share one set of
// inputs: 0 = BYPASS 1 / 16 regs, 1 = BYPASS 0 / 16 regs, 2 = BYPASS 1 / 12 regs.
// Stimulus pushes expectations stamped with a cycle; the monitor compares them
// on the falling edge of that cycle.
module tb_regfile_bypass_init;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        mem_valid;
    logic [3:0]  mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  rd_d_addr;
    logic [3:0]  rd_m_addr;
    logic [3:0]  rd_c_addr;

    logic [31:0] rd_direct [3];
    logic [31:0] rd_mux    [3];
    logic [31:0] rd_cache  [3];
    logic        rdy       [3];
    logic        done      [3];
    logic [15:0] stall     [3];

    regfile_bypass_init #(
        .DATA_WIDTH(32), .REGFILE_SIZE(16), .REGFILE_ADDR_WIDTH(4), .BYPASS(1)
    ) dut_byp (
        .CLK_I(clk), .RST_I(rst), .EN_I(en),
        .RD_PORT_DIRECT_ADDR_I(rd_d_addr), .RD_PORT_MUX_ADDR_I(rd_m_addr),
        .RD_PORT_CACHE_ADDR_I(rd_c_addr),
        .RD_PORT_DIRECT_O(rd_direct[0]), .RD_PORT_MUX_O(rd_mux[0]), .RD_PORT_CACHE_O(rd_cache[0]),
        .WR_PORT_EN_I(wr_en), .WR_PORT_ADDR_I(wr_addr), .WR_PORT_DATA_I(wr_data),
        .MEM_WR_VALID_I(mem_valid), .MEM_WR_ADDR_I(mem_addr), .MEM_WR_DATA_I(mem_data),
        .MEM_WR_READY_O(rdy[0]), .INIT_DONE_O(done[0]), .MEM_STALL_CNT_O(stall[0])
    );

    regfile_bypass_init #(
        .DATA_WIDTH(32), .REGFILE_SIZE(16), .REGFILE_ADDR_WIDTH(4), .BYPASS(0)
    ) dut_nobyp (
        .CLK_I(clk), .RST_I(rst), .EN_I(en),
        .RD_PORT_DIRECT_ADDR_I(rd_d_addr), .RD_PORT_MUX_ADDR_I(rd_m_addr),
        .RD_PORT_CACHE_ADDR_I(rd_c_addr),
        .RD_PORT_DIRECT_O(rd_direct[1]), .RD_PORT_MUX_O(rd_mux[1]), .RD_PORT_CACHE_O(rd_cache[1]),
        .WR_PORT_EN_I(wr_en), .WR_PORT_ADDR_I(wr_addr), .WR_PORT_DATA_I(wr_data),
        .MEM_WR_VALID_I(mem_valid), .MEM_WR_ADDR_I(mem_addr), .MEM_WR_DATA_I(mem_data),
        .MEM_WR_READY_O(rdy[1]), .INIT_DONE_O(done[1]), .MEM_STALL_CNT_O(stall[1])
    );

    regfile_bypass_init #(
        .DATA_WIDTH(32), .REGFILE_SIZE(12), .REGFILE_ADDR_WIDTH(4), .BYPASS(1)
    ) dut_small (
        .CLK_I(clk), .RST_I(rst), .EN_I(en),
        .RD_PORT_DIRECT_ADDR_I(rd_d_addr), .RD_PORT_MUX_ADDR_I(rd_m_addr),
        .RD_PORT_CACHE_ADDR_I(rd_c_addr),
        .RD_PORT_DIRECT_O(rd_direct[2]), .RD_PORT_MUX_O(rd_mux[2]), .RD_PORT_CACHE_O(rd_cache[2]),
        .WR_PORT_EN_I(wr_en), .WR_PORT_ADDR_I(wr_addr), .WR_PORT_DATA_I(wr_data),
        .MEM_WR_VALID_I(mem_valid), .MEM_WR_ADDR_I(mem_addr), .MEM_WR_DATA_I(mem_data),
        .MEM_WR_READY_O(rdy[2]), .INIT_DONE_O(done[2]), .MEM_STALL_CNT_O(stall[2])
    );

    // Observable selectors
    localparam int S_DIR   = 0;
    localparam int S_MUX   = 1;
    localparam int S_CACHE = 2;
    localparam int S_RDY   = 3;
    localparam int S_DONE  = 4;
    localparam int S_STALL = 5;

    typedef struct {
        int          cyc;
        int          dut;
        int          sel;
        logic [31:0] exp;
        string       name;
    } item_t;

    item_t sb[$];
    int    cyc      = 0;
    int    checks   = 0;
    int    failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] obs(input int d, input int sel);
        case (sel)
            S_DIR:   return rd_direct[d];
            S_MUX:   return rd_mux[d];
            S_CACHE: return rd_cache[d];
            S_RDY:   return {31'b0, rdy[d]};
            S_DONE:  return {31'b0, done[d]};
            S_STALL: return {16'b0, stall[d]};
            default: return 32'h0;
        endcase
    endfunction

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        item_t       it;
        logic [31:0] got;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            it = sb.pop_front();
            checks++;
            if (it.cyc < cyc) begin
                failures++;
                $display("FAIL %s dut%0d: not sampled in cycle %0d (now %0d)", it.name, it.dut, it.cyc, cyc);
            end else begin
                got = obs(it.dut, it.sel);
                if (got !== it.exp) begin
                    failures++;
                    $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h", it.name, it.dut, cyc, got, it.exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect1(input int d, input int sel, input logic [31:0] e, input string nm);
        item_t it;
        it.cyc  = cyc;
        it.dut  = d;
        it.sel  = sel;
        it.exp  = e;
        it.name = nm;
        sb.push_back(it);
    endtask

    task automatic expect3(input int sel, input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input string nm);
        expect1(0, sel, e0, nm);
        expect1(1, sel, e1, nm);
        expect1(2, sel, e2, nm);
    endtask

    task automatic expect_all(input int sel, input logic [31:0] e, input string nm);
        expect3(sel, e, e, e, nm);
    endtask

    function automatic logic [31:0] b2w(input bit b);
        return b ? 32'd1 : 32'd0;
    endfunction

    // Called in the cycle reset is released; walks the whole clear sequence.
    task automatic check_init();
        expect_all(S_DONE, 0, "done_at_release");
        expect_all(S_STALL, 0, "stall_at_release");
        expect_all(S_RDY, 0, "rdy_at_release");
        for (int k = 1; k <= 17; k++) begin
            step();
            expect3(S_DONE, b2w(k >= 16), b2w(k >= 16), b2w(k >= 12), "init_done");
            expect3(S_RDY,  b2w(k >= 16), b2w(k >= 16), b2w(k >= 12), "rdy_init");
            expect_all(S_DIR, 0, "rd_during_clear");
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        rd_d_addr = 4'd3; rd_m_addr = '0; rd_c_addr = '0;

        // Reset held, then released into the clear sequence
        step(); step();
        expect_all(S_RDY, 0, "rdy_in_rst");
        expect_all(S_DIR, 0, "rd_in_rst");
        step();
        rst = 1'b0;
        check_init();

        // Every register reads zero after the clear
        for (int i = 0; i < 16; i++) begin
            step();
            rd_d_addr = 4'(i);
            expect_all(S_DIR, 0, "rd_zero");
        end

        // Core write and writeback to different addresses in one cycle
        step();
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEADBEEF;
        mem_valid = 1'b1; mem_addr = 4'd5; mem_data = 32'h12345678;
        rd_d_addr = 4'd3; rd_m_addr = 4'd5; rd_c_addr = 4'd0;
        expect_all(S_RDY, 1, "rdy_diff_addr");
        expect3(S_DIR, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, "fwd_core");
        expect3(S_MUX, 32'h12345678, 32'h0, 32'h12345678, "fwd_wb");
        expect_all(S_CACHE, 0, "rd_r0");
        step();
        wr_en = 1'b0; mem_valid = 1'b0;
        expect_all(S_DIR, 32'hDEADBEEF, "r3_stored");
        expect_all(S_MUX, 32'h12345678, "r5_stored");

        // Conflict on r7: core wins, writeback stalls one cycle
        step();
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h1;
        mem_valid = 1'b1; mem_addr = 4'd7; mem_data = 32'h2;
        rd_d_addr = 4'd7; rd_m_addr = 4'd7; rd_c_addr = 4'd3;
        expect_all(S_RDY, 0, "rdy_conflict");
        expect_all(S_STALL, 0, "stall_before");
        expect3(S_DIR, 32'h1, 32'h0, 32'h1, "r7_fwd_core");
        expect3(S_MUX, 32'h1, 32'h0, 32'h1, "r7_fwd_core_mux");
        expect_all(S_CACHE, 32'hDEADBEEF, "r3_hold");
        step();
        wr_en = 1'b0;
        expect_all(S_RDY, 1, "rdy_after_conflict");
        expect_all(S_STALL, 1, "stall_one");
        expect3(S_DIR, 32'h2, 32'h1, 32'h2, "r7_fwd_wb");
        step();
        mem_valid = 1'b0;
        expect_all(S_DIR, 32'h2, "r7_final");
        expect_all(S_STALL, 1, "stall_keep");

        // Same-cycle forwarding on all three ports
        step();
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'hA5A5A5A5;
        rd_d_addr = 4'd2; rd_m_addr = 4'd2; rd_c_addr = 4'd2;
        expect3(S_DIR,   32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, "r2_fwd_dir");
        expect3(S_MUX,   32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, "r2_fwd_mux");
        expect3(S_CACHE, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, "r2_fwd_cache");
        step();
        wr_en = 1'b0;
        expect_all(S_DIR,   32'hA5A5A5A5, "r2_dir");
        expect_all(S_MUX,   32'hA5A5A5A5, "r2_mux");
        expect_all(S_CACHE, 32'hA5A5A5A5, "r2_cache");

        // Address 13: in range for 16 regs, out of range for 12
        step();
        wr_en = 1'b1; wr_addr = 4'd13; wr_data = 32'hCAFEF00D;
        rd_d_addr = 4'd13; rd_m_addr = 4'd3; rd_c_addr = 4'd5;
        expect3(S_DIR, 32'hCAFEF00D, 32'h0, 32'h0, "a13_core");
        step();
        wr_en = 1'b0;
        mem_valid = 1'b1; mem_addr = 4'd13; mem_data = 32'h0BADF00D;
        expect_all(S_RDY, 1, "rdy_a13");
        expect3(S_DIR, 32'h0BADF00D, 32'hCAFEF00D, 32'h0, "a13_wb");
        step();
        mem_valid = 1'b0;
        expect3(S_DIR, 32'h0BADF00D, 32'h0BADF00D, 32'h0, "a13_after");
        expect_all(S_MUX, 32'hDEADBEEF, "r3_untouched");
        expect_all(S_CACHE, 32'h12345678, "r5_untouched");
        expect_all(S_STALL, 1, "stall_a13");

        // EN_I low: no writes, stall counter runs to saturation
        step();
        en = 1'b0;
        mem_valid = 1'b1; mem_addr = 4'd9; mem_data = 32'h99;
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'h44;
        rd_d_addr = 4'd4; rd_m_addr = 4'd9;
        expect_all(S_RDY, 0, "rdy_en0");
        expect_all(S_STALL, 1, "stall_s0");
        expect_all(S_DIR, 0, "no_core_en0");
        expect_all(S_MUX, 0, "no_wb_en0");
        repeat (65533) step();
        expect_all(S_STALL, 32'h0000FFFE, "stall_fffe");
        expect_all(S_DIR, 0, "r4_still0");
        step();
        expect_all(S_STALL, 32'h0000FFFF, "stall_sat");
        repeat (4466) step();
        expect_all(S_STALL, 32'h0000FFFF, "stall_hold");

        // Reset in RUN with a pending write, then again mid-clear
        step();
        en = 1'b1; mem_valid = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h33;
        rd_d_addr = 4'd3;
        rst = 1'b1;
        expect_all(S_RDY, 0, "rdy_in_rst2");
        expect_all(S_DIR, 0, "rd_in_rst2");
        step();
        rst = 1'b0; wr_en = 1'b0;
        expect_all(S_STALL, 0, "stall_cleared");
        expect_all(S_DONE, 0, "done_cleared");
        repeat (5) step();
        expect_all(S_DONE, 0, "done_mid_clear");
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_init();
        step();
        rd_d_addr = 4'd3;
        expect_all(S_DIR, 0, "r3_recleared");
        step();
        rd_d_addr = 4'd7;
        expect_all(S_DIR, 0, "r7_recleared");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            checks   += sb.size();
            failures += sb.size();
            $display("FAIL drain: %0d expectations never sampled", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_bypass_init.md
REGFILE_BYPASS_INIT -- requirements
Module: regfile_bypass_init

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: register word width.
REQ-002 The block SHALL have parameter REGFILE_SIZE, default 16: number of registers, 2..2**REGFILE_ADDR_WIDTH.
REQ-003 The block SHALL have parameter REGFILE_ADDR_WIDTH, default 4: address width of every port.
REQ-004 The block SHALL have parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding, 0 = reads return the stored value.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 CLK_I  in  1  the clock; all state updates on its rising edge.
REQ-007 RST_I  in  1  synchronous active-high reset.
REQ-008 EN_I  in  1  global enable; when 0, no write of any kind is accepted.
REQ-009 RD_PORT_DIRECT_ADDR_I / RD_PORT_MUX_ADDR_I / RD_PORT_CACHE_ADDR_I  in  REGFILE_ADDR_WIDTH each  the read addresses.
REQ-010 RD_PORT_DIRECT_O / RD_PORT_MUX_O / RD_PORT_CACHE_O  out  DATA_WIDTH each  the combinational read data.
REQ-011 WR_PORT_EN_I  in  1;  WR_PORT_ADDR_I  in  REGFILE_ADDR_WIDTH;  WR_PORT_DATA_I  in  DATA_WIDTH  form the core write port.
REQ-012 MEM_WR_VALID_I  in  1;  MEM_WR_ADDR_I  in  REGFILE_ADDR_WIDTH;  MEM_WR_DATA_I  in  DATA_WIDTH  form the memory-load writeback request.
REQ-013 MEM_WR_READY_O  out  1  is the writeback acceptance signal.
REQ-014 INIT_DONE_O  out  1  is 1 once the clear sequence has completed.
REQ-015 MEM_STALL_CNT_O  out  16  is the saturating count of stalled writeback cycles.

Function
REQ-016 The block SHALL implement a two-state FSM, CLEAR and RUN, with a clear counter clr_cnt of REGFILE_ADDR_WIDTH bits.
REQ-017 In CLEAR, the block SHALL write 0 to memory[clr_cnt] and increment clr_cnt every cycle, independent of EN_I.
REQ-018 The FSM SHALL transition CLEAR->RUN in the cycle after clr_cnt==REGFILE_SIZE-1 is written; CLEAR therefore lasts exactly REGFILE_SIZE cycles.
REQ-019 RUN SHALL be left only by reset.
REQ-020 In CLEAR: MEM_WR_READY_O=0, INIT_DONE_O=0, all read outputs forced to 0, and core writes ignored.
REQ-021 In RUN, a core write SHALL be accepted when WR_PORT_EN_I && EN_I, and memory[WR_PORT_ADDR_I] SHALL update at the next edge.
REQ-022 MEM_WR_READY_O SHALL be combinational: RUN && EN_I && !(WR_PORT_EN_I && WR_PORT_ADDR_I==MEM_WR_ADDR_I).
REQ-023 A writeback SHALL be accepted when MEM_WR_VALID_I && MEM_WR_READY_O, and memory[MEM_WR_ADDR_I] SHALL update at the next edge.
REQ-024 A core write and a writeback to different addresses SHALL both complete in the same cycle.
REQ-025 On an address conflict, the core write SHALL win and the writeback SHALL stall; the requester holds valid, address and data until accepted.
REQ-026 If BYPASS=1, a read whose address matches an accepted write this cycle SHALL return that write's data, core data taking precedence over writeback data.
REQ-027 If BYPASS=0, reads SHALL return the stored value only, giving the new value one cycle after the write.
REQ-028 An address >= REGFILE_SIZE SHALL be ignored on write, SHALL read as 0, and SHALL never be forwarded.
REQ-029 A writeback to an out-of-range address SHALL still be handshaken (ready per REQ-022) and then dropped.
REQ-030 MEM_STALL_CNT_O SHALL increment on each RUN cycle with MEM_WR_VALID_I && !MEM_WR_READY_O, saturating at 0xFFFF.
REQ-031 The block SHALL be fully synchronous with no latches; read paths SHALL be combinational, and write latency SHALL be 1 cycle.

Reset
REQ-032 RST_I=1 at an edge SHALL set FSM=CLEAR, clr_cnt=0, MEM_STALL_CNT_O=0 and INIT_DONE_O=0.
REQ-033 While RST_I is asserted, MEM_WR_READY_O=0, read outputs=0, and no register SHALL be written.
REQ-034 Reset asserted mid-CLEAR or mid-RUN SHALL restart the full clear sequence; pending writes that cycle SHALL be discarded.
REQ-035 Register contents are undefined until the clear completes and SHALL never be observable before INIT_DONE_O=1.

Verification (DATA_WIDTH=32, REGFILE_SIZE=16 unless stated)
REQ-036 The bench SHALL cover: release reset -> INIT_DONE_O rises exactly 16 cycles later, and all 16 registers read 0 on the direct port.
REQ-037 The bench SHALL cover: RUN, core write r3=0xDEADBEEF and writeback r5=0x12345678 in the same cycle -> both ready; next cycle r3 and r5 read those values.
REQ-038 The bench SHALL cover: core write r7=0x1 and writeback r7=0x2 held valid -> ready=0 for 1 cycle, stall count 1, then r7=0x2 after the writeback is accepted.
REQ-039 The bench SHALL cover: BYPASS=1 with a core write of r2=0xA5A5A5A5 and all read ports at r2 in the same cycle -> all outputs 0xA5A5A5A5 that cycle; BYPASS=0 -> old value that cycle, new value the next.
REQ-040 The bench SHALL cover: REGFILE_SIZE=12, write address 13 -> no register changes, read of 13 returns 0, writeback to 13 is handshaken and dropped.
REQ-041 The bench SHALL cover: EN_I=0 with valid held for 70000 cycles -> counter saturates at 0xFFFF; then reset at cycle 5 of a new CLEAR -> counter is 0 and INIT_DONE_O comes 16 cycles after release.
